// File: rtl/seq_det_100101.sv
// -----------------------------------------------------------------------------
// seq_det_100101
//   Serial pattern detector for the sequence 1-0-0-1-0-1 (first-received bit
//   first). It sits downstream of the 6-bit pattern generator and consumes its
//   1-bit stream, one qualified bit per clk.
//
//   Outputs are a registered one-cycle detect pulse, a saturating hit counter
//   and a 6-bit window of the most recent valid bits for LEDs and debug.
//
// Parameters
//   CNT_W      width of match_cnt (>= 1)
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   clr        in   1      synchronous active-high reset
//   din        in   1      serial data bit
//   din_vld    in   1      qualifies din; 0 = bubble, nothing advances
//   detect     out  1      one-cycle pulse, pattern completed on last valid bit
//   match_cnt  out  CNT_W  detections since clr, saturates at all-ones
//   state      out  3      current FSM state code (debug)
//   window     out  6      last 6 valid bits, bit0 = newest
//
// Configuration macro
//   SEQDET_NOOVERLAP_EN  defined: non-overlapping detection (MATCH -> S0)
//                        undefined (default): overlapping (MATCH -> S1)
//
// State table
//   state | meaning
//   S0    | no pattern bits matched
//   S1    | matched "1"
//   S2    | matched "10"
//   S3    | matched "100"
//   S4    | matched "1001"
//   S5    | matched "10010"
//   6, 7  | unused, recover to S0 on the next edge
// -----------------------------------------------------------------------------
module seq_det_100101 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             din,
    input  logic             din_vld,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       state,
    output logic [5:0]       window
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;

    // Where the FSM resumes after a completed pattern. In overlap mode the
    // final '1' doubles as the first bit of the next pattern.
`ifdef SEQDET_NOOVERLAP_EN
    localparam logic [2:0] S_AFTER_MATCH = S0;
`else
    localparam logic [2:0] S_AFTER_MATCH = S1;
`endif

    logic [2:0] state_nxt;
    logic       hit;

    always_comb begin
        state_nxt = state;
        hit       = 1'b0;
        case (state)
            S0: if (din_vld) state_nxt = din ? S1 : S0;
            S1: if (din_vld) state_nxt = din ? S1 : S2;
            S2: if (din_vld) state_nxt = din ? S1 : S3;
            S3: if (din_vld) state_nxt = din ? S4 : S0;
            S4: if (din_vld) state_nxt = din ? S1 : S5;
            S5: begin
                if (din_vld) begin
                    if (din) begin
                        state_nxt = S_AFTER_MATCH;
                        hit       = 1'b1;
                    end else begin
                        state_nxt = S3;
                    end
                end
            end
            // Unused codes recover regardless of din_vld.
            default: state_nxt = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S0;
            detect    <= 1'b0;
            match_cnt <= '0;
            window    <= '0;
        end else begin
            state  <= state_nxt;
            detect <= hit;
            if (hit && (match_cnt != {CNT_W{1'b1}}))
                match_cnt <= match_cnt + CNT_W'(1);
            if (din_vld)
                window <= {window[4:0], din};
        end
    end

endmodule

// File: tb/tb_seq_det_100101.sv
module tb_seq_det_100101;

    logic       clk = 1'b0;
    logic       clr;
    logic       din;
    logic       din_vld;

    logic       detect;
    logic [7:0] match_cnt;
    logic [2:0] state;
    logic [5:0] window;

    logic       detect_s;
    logic [1:0] match_cnt_s;
    logic [2:0] state_s;
    logic [5:0] window_s;

    int n_chk = 0;
    int n_err = 0;

`ifdef SEQDET_NOOVERLAP_EN
    localparam bit OVL = 1'b0;
`else
    localparam bit OVL = 1'b1;
`endif

    always #5 clk = ~clk;

    seq_det_100101 #(.CNT_W(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .din       (din),
        .din_vld   (din_vld),
        .detect    (detect),
        .match_cnt (match_cnt),
        .state     (state),
        .window    (window)
    );

    // Narrow counter instance, shares stimulus, used for saturation checks.
    seq_det_100101 #(.CNT_W(2)) dut_sat (
        .clk       (clk),
        .clr       (clr),
        .din       (din),
        .din_vld   (din_vld),
        .detect    (detect_s),
        .match_cnt (match_cnt_s),
        .state     (state_s),
        .window    (window_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on negedge; outputs are sampled on the following negedge.
    task automatic send(input logic b);
        din     = b;
        din_vld = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_clr();
        clr     = 1'b1;
        din     = 1'b0;
        din_vld = 1'b0;
        @(negedge clk);
        clr     = 1'b0;
    endtask

    // Feed n bits MSB-first, checking detect after each against det_mask.
    task automatic feed(input logic [15:0] bits, input int n,
                        input logic [15:0] det_mask, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i]);
            chk(tag, detect, det_mask[i]);
        end
    endtask

    initial begin
        int det_seen;

        clr     = 1'b1;
        din     = 1'b0;
        din_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state",  state,     0);
        chk("rst_detect", detect,    0);
        chk("rst_cnt",    match_cnt, 0);
        chk("rst_window", window,    0);
        clr = 1'b0;

        // Basic detection
        feed(16'b100101, 6, 16'b000001, "t1_det");
        chk("t1_cnt",    match_cnt, 1);
        chk("t1_window", window,    6'b100101);
        chk("t1_state",  state,     OVL ? 1 : 0);
        din_vld = 1'b0;
        @(negedge clk);
        chk("t1_pulse_one_cycle", detect, 0);

        // Overlap: second pattern reuses the final '1' of the first
        do_clr();
        feed(16'b10010100101, 11, OVL ? 16'b00000100001 : 16'b00000100000, "t2_det");
        chk("t2_cnt",    match_cnt, OVL ? 2 : 1);
        chk("t2_window", window,    6'b100101);

        // Bubbles hold everything
        do_clr();
        feed(16'b100, 3, 16'b000, "t3_det_a");
        for (int i = 0; i < 3; i++) begin
            din     = 1'b1;
            din_vld = 1'b0;
            @(negedge clk);
            chk("t3_bub_state",  state,  3);
            chk("t3_bub_detect", detect, 0);
            chk("t3_bub_window", window, 6'b000100);
        end
        feed(16'b101, 3, 16'b001, "t3_det_b");
        chk("t3_cnt", match_cnt, 1);

        // Near-miss: S5 then '0' falls back to S3
        do_clr();
        feed(16'b100100, 6, 16'b000000, "t4_det_a");
        chk("t4_state_s3", state, 3);
        feed(16'b101, 3, 16'b001, "t4_det_b");
        chk("t4_cnt", match_cnt, 1);
        do_clr();
        feed(16'b1000, 4, 16'b0000, "t4_det_c");
        chk("t4_state_s0", state, 0);

        // Saturation on the narrow counter
        do_clr();
        for (int k = 1; k <= 5; k++) begin
            feed(16'b100101, 6, 16'b000001, "t5_det");
            chk("t5_sat_det",  detect_s,    1);
            chk("t5_sat_cnt",  match_cnt_s, (k > 3) ? 3 : k);
            chk("t5_wide_cnt", match_cnt,   k);
        end

        // clr mid-pattern wins over a valid bit
        do_clr();
        feed(16'b10010, 5, 16'b00000, "t6_det");
        clr     = 1'b1;
        din     = 1'b1;
        din_vld = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        din_vld = 1'b0;
        chk("t6_detect", detect,      0);
        chk("t6_state",  state,       0);
        chk("t6_cnt",    match_cnt,   0);
        chk("t6_cnt_s",  match_cnt_s, 0);
        chk("t6_window", window,      0);
        @(negedge clk);
        chk("t6_no_late_det", detect, 0);

        // Continuous stream from the generator
        do_clr();
        det_seen = 0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 5; i >= 0; i--) begin
                logic [5:0] pat;
                pat = 6'b100101;
                send(pat[i]);
                if (detect) det_seen++;
            end
        end
        chk("t7_pulses", det_seen,  4);
        chk("t7_cnt",    match_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
